mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, is the memory address width.
REQ-002 Parameter DATA_WIDTH, default 32, is the memory data width.
REQ-003 Parameter MAX_BURST, default 4, range 1..16, is the maximum number of consecutive transfers one requester may make while the other is waiting.
REQ-004 Port sys_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port sys_rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Ports m0_req / m1_req, input, 1 bit each: requester 0 (CPU) / requester 1 (DMA or debug) wants a transfer this cycle.
REQ-007 Ports m0_wr_en / m1_wr_en, input, 1 bit each: the transfer is a write (1) or a read (0).
REQ-008 Ports m0_addr / m1_addr, input, ADDR_WIDTH each: transfer address.
REQ-009 Ports m0_wdata / m1_wdata, input, DATA_WIDTH each: write data.
REQ-010 Ports m0_gnt / m1_gnt, output, 1 bit each: the requester owns the memory port this cycle.
REQ-011 Ports m0_rdata / m1_rdata, output, DATA_WIDTH each: read data.
REQ-012 Ports m0_rvalid / m1_rvalid, output, 1 bit each: the matching rdata is valid this cycle.
REQ-013 Port mem_wr_en, output, 1 bit: memory write enable.
REQ-014 Port mem_addr, output, ADDR_WIDTH: memory address.
REQ-015 Port mem_data_in, output, DATA_WIDTH: memory write data.
REQ-016 Port mem_data_out, input, DATA_WIDTH: memory read data; the memory read latency is 1 cycle.

Function
REQ-017 The FSM SHALL have states IDLE, GRANT_M0 and GRANT_M1; mX_gnt SHALL equal (state==GRANT_MX), with at most one grant high in any cycle.
REQ-018 A transfer by requester X SHALL occur in every cycle where mX_req and mX_gnt are both 1.
REQ-019 IDLE transitions: only m0_req -> GRANT_M0; only m1_req -> GRANT_M1; both -> the requester not equal to last_owner; neither -> stay IDLE.
REQ-020 From GRANT_MX, when mX_req is 0: go to GRANT_MY if mY_req is 1, else go to IDLE.
REQ-021 From GRANT_MX, on a transfer with burst_cnt==MAX_BURST-1 and mY_req==1: go to GRANT_MY; otherwise stay in GRANT_MX.
REQ-022 burst_cnt SHALL increment on each transfer and clear on any state change.
REQ-023 In GRANT_MX, a transfer at burst_cnt==MAX_BURST-1 while mY_req==0 SHALL clear burst_cnt to 0 and keep the grant (no wrap-through-saturation).
REQ-024 last_owner SHALL update to X whenever the FSM leaves GRANT_MX.
REQ-025 The first transfer latency from IDLE SHALL be 1 cycle: req is sampled in cycle N and gnt is high in cycle N+1.
REQ-026 mem_addr, mem_data_in and mem_wr_en SHALL come combinationally from the granted requester.
REQ-027 mem_wr_en SHALL be 1 only on a write transfer; with no transfer, all three memory outputs SHALL be 0.
REQ-028 mX_rvalid SHALL be registered, asserting for exactly one cycle, one cycle after a read transfer by X.
REQ-029 m0_rdata and m1_rdata SHALL both equal mem_data_out.
REQ-030 A read in flight when the grant switches SHALL still raise the rvalid of its original requester.
REQ-031 Writes SHALL never raise rvalid.
REQ-032 With MAX_BURST=1 and both requesters continuously requesting, grants SHALL strictly alternate every cycle.

Reset
REQ-033 While sys_rst is 1 at a clock edge, the block SHALL set: state=IDLE, burst_cnt=0, last_owner=M1 (so M0 wins the first tie), m0_rvalid=m1_rvalid=0.
REQ-034 While state is IDLE during reset, both gnt outputs SHALL be 0 and mem_wr_en SHALL be 0.
REQ-035 A reset asserted mid-burst SHALL abandon the burst and drop any pending rvalid.

Structure
REQ-036 The arb_state_t enum (IDLE, GRANT_M0, GRANT_M1) SHALL live in pkg_cpu_typedefs.
REQ-037 burst_cnt width SHALL be max(1, $clog2(MAX_BURST)).
REQ-038 The block SHALL be a single module with no sub-module; round-robin selection is inline.

Verification
REQ-039 Reset then m0_req=1 read addr 0x10 in cycle 1 -> m0_gnt=1 in cycle 2, mem_addr=0x10, mem_wr_en=0; m0_rvalid=1 in cycle 3 with m0_rdata=mem_data_out.
REQ-040 Both req high from cycle 1 with MAX_BURST=4 -> M0 granted first, 4 transfers, then M1 granted for 4, then M0; no cycle with two gnts.
REQ-041 m1 write addr 0x20 data 0xDEADBEEF alone -> mem_wr_en=1, mem_addr=0x20, mem_data_in=0xDEADBEEF for one cycle; m1_rvalid stays 0.
REQ-042 M0 read on the last burst beat with M1 waiting -> next cycle m1_gnt=1 and m0_rvalid=1 simultaneously.
REQ-043 M0 drops req after 2 transfers with M1 idle -> IDLE next cycle; then both request -> M1 wins (last_owner=M0).
REQ-044 sys_rst=1 in the middle of a burst -> next cycle both gnt=0, rvalid=0, burst_cnt=0; after release, a tie goes to M0.

Source files
------------

// File: rtl/pkg_cpu_typedefs.sv
// Shared types for the memory bus arbiter: FSM states, owner encoding and
// the burst counter width helper.
package pkg_cpu_typedefs;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_M0 = 2'd1,
    GRANT_M1 = 2'd2
  } arb_state_t;

  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Two-requester memory port arbiter: round-robin on ties, bounded bursts,
// registered per-requester read-valid with one-cycle memory latency.
module mem_bus_arbiter
  import pkg_cpu_typedefs::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  m0_req,
  input  logic                  m0_wr_en,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic                  m1_req,
  input  logic                  m1_wr_en,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m0_gnt,
  output logic                  m1_gnt,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m0_rvalid,
  output logic                  m1_rvalid,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  localparam int            CW        = cnt_w(MAX_BURST);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  arb_state_t    state, state_nxt;
  logic [CW-1:0] burst_cnt, burst_nxt;
  logic          last_owner, last_owner_nxt;
  logic          xfer0, xfer1, last_beat;

  assign m0_gnt    = (state == GRANT_M0);
  assign m1_gnt    = (state == GRANT_M1);
  assign xfer0     = m0_gnt & m0_req;
  assign xfer1     = m1_gnt & m1_req;
  assign last_beat = (burst_cnt == LAST_BEAT);
  assign m0_rdata  = mem_data_out;
  assign m1_rdata  = mem_data_out;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (m0_req && m1_req)
          state_nxt = (last_owner == OWNER_M1) ? GRANT_M0 : GRANT_M1;
        else if (m0_req) state_nxt = GRANT_M0;
        else if (m1_req) state_nxt = GRANT_M1;
      end
      GRANT_M0: begin
        if (!m0_req)                state_nxt = m1_req ? GRANT_M1 : IDLE;
        else if (last_beat && m1_req) state_nxt = GRANT_M1;
      end
      GRANT_M1: begin
        if (!m1_req)                state_nxt = m0_req ? GRANT_M0 : IDLE;
        else if (last_beat && m0_req) state_nxt = GRANT_M0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A full burst with nobody waiting restarts the count rather than saturating.
  always_comb begin
    burst_nxt      = burst_cnt;
    last_owner_nxt = last_owner;
    if (state_nxt != state) begin
      burst_nxt = '0;
      if (state == GRANT_M0) last_owner_nxt = OWNER_M0;
      if (state == GRANT_M1) last_owner_nxt = OWNER_M1;
    end else if (xfer0 || xfer1) begin
      burst_nxt = last_beat ? '0 : burst_cnt + 1'b1;
    end
  end

  always_comb begin
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    if (xfer0) begin
      mem_wr_en   = m0_wr_en;
      mem_addr    = m0_addr;
      mem_data_in = m0_wdata;
    end else if (xfer1) begin
      mem_wr_en   = m1_wr_en;
      mem_addr    = m1_addr;
      mem_data_in = m1_wdata;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      last_owner <= OWNER_M1;
      m0_rvalid  <= 1'b0;
      m1_rvalid  <= 1'b0;
    end else begin
      state      <= state_nxt;
      burst_cnt  <= burst_nxt;
      last_owner <= last_owner_nxt;
      m0_rvalid  <= xfer0 & ~m0_wr_en;
      m1_rvalid  <= xfer1 & ~m1_wr_en;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed scenarios push expected
// transfers/read returns; a negedge monitor pops and compares.
module tb_mem_bus_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        m0_req, m0_wr_en, m1_req, m1_wr_en;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_wr_en;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_data_in;
  logic [31:0] mem_data_out = '0;

  typedef struct {int cyc; bit id; bit wr; logic [31:0] addr; logic [31:0] data;} xfer_t;
  typedef struct {int cyc; bit id; logic [31:0] data;} rd_t;

  xfer_t xq[$];
  rd_t   rq[$];
  int    cyc = 0;
  int    errors = 0;
  int    checks = 0;

  mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_BURST(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m0_req(m0_req), .m0_wr_en(m0_wr_en), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_wr_en(m1_wr_en), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a ^ 32'hA5A5_0F0F;
  endfunction

  // One-cycle-latency memory: returns a pattern derived from the address.
  always @(posedge sys_clk) mem_data_out <= mem_val(mem_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic exp_x(input bit id, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input int c, input bit rv);
    xq.push_back('{c, id, wr, a, d});
    if (!wr && rv) rq.push_back('{c + 1, id, mem_val(a)});
  endtask

  task automatic drive0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    m0_req = r; m0_wr_en = w; m0_addr = a; m0_wdata = d;
  endtask

  task automatic drive1(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    m1_req = r; m1_wr_en = w; m1_addr = a; m1_wdata = d;
  endtask

  task automatic rst_pulse();
    sys_rst = 1'b1;
    step(2);
    sys_rst = 1'b0;
  endtask

  always @(negedge sys_clk) begin : mon
    xfer_t e;
    rd_t   r;
    if (m0_gnt && m1_gnt) chk("two_gnts", 1, 0);
    if ((m0_gnt && m0_req) || (m1_gnt && m1_req)) begin
      if (xq.size() == 0) chk("unexpected_xfer", cyc, 0);
      else begin
        e = xq.pop_front();
        chk("xfer_cycle", cyc, e.cyc);
        chk("xfer_owner", m1_gnt, e.id);
        chk("xfer_wr", mem_wr_en, e.wr);
        chk("xfer_addr", mem_addr, e.addr);
        chk("xfer_wdata", mem_data_in, e.data);
      end
    end else if (!sys_rst) begin
      chk("idle_mem_outs", {mem_wr_en, mem_addr, mem_data_in}, 65'd0);
    end
    if (m0_rvalid && m1_rvalid) chk("two_rvalids", 1, 0);
    if (m0_rvalid || m1_rvalid) begin
      if (rq.size() == 0) chk("unexpected_rvalid", cyc, 0);
      else begin
        r = rq.pop_front();
        chk("rvalid_cycle", cyc, r.cyc);
        chk("rvalid_owner", m1_rvalid, r.id);
        chk("m0_rdata", m0_rdata, r.data);
        chk("m1_rdata", m1_rdata, r.data);
      end
    end
  end

  initial begin
    int c;
    drive0(0, 0, '0, '0);
    drive1(0, 0, '0, '0);
    sys_rst = 1'b1;
    step(2);
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m1_gnt", m1_gnt, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    sys_rst = 1'b0;

    // Single M0 read: grant one cycle after request, rvalid one after that.
    c = cyc;
    exp_x(0, 0, 32'h10, 32'h0, c + 1, 1);
    drive0(1, 0, 32'h10, 32'h0);
    step(1);
    chk("t1_m0_gnt", m0_gnt, 1);
    step(1);
    m0_req = 0;
    step(3);

    // Both requesting: 4 beats M0, 4 beats M1, then back to M0.
    rst_pulse();
    c = cyc;
    for (int i = 1; i <= 4; i++) exp_x(0, 0, 32'h100, 32'h1111, c + i, 1);
    for (int i = 5; i <= 8; i++) exp_x(1, 0, 32'h200, 32'h2222, c + i, 1);
    for (int i = 9; i <= 10; i++) exp_x(0, 0, 32'h100, 32'h1111, c + i, 1);
    drive0(1, 0, 32'h100, 32'h1111);
    drive1(1, 0, 32'h200, 32'h2222);
    step(11);
    m0_req = 0; m1_req = 0;
    step(3);

    // Lone M1 write: no rvalid.
    c = cyc;
    exp_x(1, 1, 32'h20, 32'hDEADBEEF, c + 1, 0);
    drive1(1, 1, 32'h20, 32'hDEADBEEF);
    step(2);
    drive1(0, 0, '0, '0);
    step(3);

    // M0 alone beyond MAX_BURST keeps the grant.
    c = cyc;
    for (int i = 1; i <= 6; i++) exp_x(0, 1, 32'h70, 32'h7777, c + i, 0);
    drive0(1, 1, 32'h70, 32'h7777);
    step(7);
    drive0(0, 0, '0, '0);
    step(3);

    // M0 drops after 2 beats -> IDLE; following tie goes to M1.
    rst_pulse();
    c = cyc;
    exp_x(0, 0, 32'h30, 32'h0, c + 1, 1);
    exp_x(0, 0, 32'h30, 32'h0, c + 2, 1);
    exp_x(1, 0, 32'h40, 32'h0, c + 5, 1);
    drive0(1, 0, 32'h30, 32'h0);
    step(3);
    m0_req = 0;
    step(1);
    chk("t5_idle_gnts", {m0_gnt, m1_gnt}, 0);
    drive0(1, 0, 32'h30, 32'h0);
    drive1(1, 0, 32'h40, 32'h0);
    step(2);
    m0_req = 0; m1_req = 0;
    step(3);

    // Reset mid-burst drops the pending rvalid; tie afterwards goes to M0.
    rst_pulse();
    c = cyc;
    exp_x(0, 0, 32'h50, 32'h0, c + 1, 1);
    exp_x(0, 0, 32'h50, 32'h0, c + 2, 0);
    for (int i = 5; i <= 8; i++) exp_x(0, 0, 32'h50, 32'h0, c + i, 1);
    drive0(1, 0, 32'h50, 32'h0);
    drive1(1, 0, 32'h60, 32'h0);
    step(2);
    sys_rst = 1'b1;
    step(1);
    chk("t6_rst_gnts", {m0_gnt, m1_gnt}, 0);
    chk("t6_rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    step(1);
    sys_rst = 1'b0;
    step(5);
    m0_req = 0; m1_req = 0;
    step(4);

    chk("xfer_queue_drained", xq.size(), 0);
    chk("read_queue_drained", rq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
